// File: rtl/line_mem_responder.sv
// Memory-side responder for a 128-bit cache line interface: fixed-latency line RAM,
// initiator protocol checking and saturating completion counters.
module line_mem_responder #(
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned ADDR_W    = 10,
    // Reset value of both completion counters; nonzero only to reach saturation quickly.
    parameter logic [15:0] CNT_RESET = 16'h0000
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt,
    output logic [1:0]   dbg_state_o
);

    // Handshake: mem_read/mem_write are levels held by the initiator until it samples
    // mem_ready; mem_ready pulses for one cycle per accepted request; a request that
    // drops before mem_ready, or both lines high in IDLE, is a protocol error.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [127:0]        wdata_q, wdata_d;
    logic [127:0]        rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;

    logic [127:0]        mem_q [0:DEPTH-1];

    logic                complete;
    logic                done_wr;
    logic [ADDR_W-1:0]   done_idx;
    logic [127:0]        done_wdata;
    logic                mem_we;
    logic                req_held;

    // Upper address bits alias onto the same line index.
    logic                unused_addr;
    assign unused_addr = ^mem_addr[27:ADDR_W];

    assign req_held = op_wr_q ? mem_write : mem_read;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        complete   = 1'b0;
        done_wr    = op_wr_q;
        done_idx   = idx_q;
        done_wdata = wdata_q;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    op_wr_d = mem_write;
                    idx_d   = mem_addr[ADDR_W-1:0];
                    wdata_d = mem_wdata;
                    cnt_d   = LAT_M1;
                    // A single-cycle latency completes from the live request, not the latches.
                    if (LATENCY == 1) begin
                        complete   = 1'b1;
                        done_wr    = mem_write;
                        done_idx   = mem_addr[ADDR_W-1:0];
                        done_wdata = mem_wdata;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!req_held) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        complete = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            if (done_wr) begin
                mem_we = !proc_reset;
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end else begin
                rdata_d = mem_q[done_idx];
                if (rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= CNT_RESET;
            wr_cnt_q <= CNT_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage is never cleared; its contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[done_idx] <= done_wdata;
        end
    end

    assign mem_rdata   = rdata_q;
    assign mem_ready   = ready_q;
    assign proto_err   = err_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
    assign dbg_state_o = state_q;

endmodule
